// File: rtl/keypad_pkg.sv
// Shared types, key codes and the 4x4 key map for the matrix keypad front end.
// Latency: n/a (definitions only). Backpressure: n/a.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      EMIT     = 2'd2,
      HELD     = 2'd3
   } state_e;

   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   // Indexed [row][column].
   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'd1,     4'd2, 4'd3,     KEY_A},
      '{4'd4,     4'd5, 4'd6,     KEY_B},
      '{4'd7,     4'd8, 4'd9,     KEY_C},
      '{KEY_STAR, 4'd0, KEY_HASH, KEY_D}
   };

   function automatic logic [2:0] rows_low(input logic [3:0] rows);
      rows_low = '0;
      for (int i = 0; i < 4; i++) begin
         rows_low = rows_low + {2'b00, ~rows[i]};
      end
   endfunction

   function automatic logic [1:0] row_index(input logic [3:0] rows);
      row_index = '0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) row_index = 2'(i);
      end
   endfunction

endpackage

// File: rtl/keypad_sync_debounce.sv
// Two-flop row synchroniser plus a counter of consecutive samples equal to a reference pattern.
// Latency: 2 cycles row_sense to rs_o, count updates on the sample cycle. Backpressure: none.
module keypad_sync_debounce #(
   parameter int DEBOUNCE_CNT = 4,
   parameter int CW           = 3
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [3:0]    row_sense_i,
   input  logic          sample_i,
   input  logic          load_i,
   input  logic [3:0]    ref_i,
   output logic [3:0]    rs_o,
   output logic          match_o,
   output logic [CW-1:0] cnt_o
);

   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);

   logic [3:0]    meta_q;
   logic [3:0]    rs_q;
   logic [3:0]    ref_q, ref_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // A load restarts the run; it counts as the first match when it lands on a matching sample.
   always_comb begin
      ref_d = ref_q;
      cnt_d = cnt_q;
      if (load_i) begin
         ref_d = ref_i;
         cnt_d = (sample_i && (rs_q == ref_i)) ? CW'(1) : '0;
      end else if (sample_i) begin
         if (rs_q == ref_q) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
         end else begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 4'hF;
         rs_q   <= 4'hF;
         ref_q  <= 4'hF;
         cnt_q  <= '0;
      end else begin
         meta_q <= row_sense_i;
         rs_q   <= meta_q;
         ref_q  <= ref_d;
         cnt_q  <= cnt_d;
      end
   end

   assign rs_o    = rs_q;
   assign match_o = (rs_q == ref_q);
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, debounce FSM and key decode to one registered strobe per press.
// Latency: strobe 1 cycle after the final matching sample. Backpressure: none, strobes are fire-and-forget.
module keypad_scanner #(
   parameter int SCAN_DIV     = 16,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_sense,
   output logic [3:0] col_drive,
   output logic [3:0] keypad_in,
   output logic       enter,
   output logic       start,
   output logic       aux_strobe,
   output logic       key_held,
   output logic       ghost_err
);

   import keypad_pkg::*;

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [SW-1:0] DIV_LAST = SW'(SCAN_DIV - 1);

   state_e        state_q, state_d;
   logic [1:0]    col_q, col_d;
   logic [SW-1:0] div_q, div_d;
   logic [1:0]    row_q, row_d;
   logic [3:0]    key_q, key_d;
   logic          enter_q, enter_d;
   logic          start_q, start_d;
   logic          aux_q, aux_d;
   logic          held_q, held_d;
   logic          ghost_q, ghost_d;

   logic [3:0]    rs;
   logic          deb_match;
   logic [CW-1:0] deb_cnt;
   logic          sample;
   logic          load;
   logic [3:0]    ref_pat;
   logic [1:0]    row_sel;
   logic [3:0]    code;
   logic          reached;

   keypad_sync_debounce #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .CW           (CW)
   ) u_sync_debounce (
      .clk_i       (clk),
      .rst_i       (rst),
      .row_sense_i (row_sense),
      .sample_i    (sample),
      .load_i      (load),
      .ref_i       (ref_pat),
      .rs_o        (rs),
      .match_o     (deb_match),
      .cnt_o       (deb_cnt)
   );

   // The slot divider free-runs; only the column index freezes while a key is tracked.
   assign sample  = (div_q == DIV_LAST);
   assign div_d   = sample ? '0 : div_q + SW'(1);
   assign reached = deb_match && ((int'(deb_cnt) + 1) >= DEBOUNCE_CNT);
   assign row_sel = (state_q == SCAN) ? row_index(rs) : row_q;
   assign code    = KEYMAP[row_sel][col_q];

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      load    = 1'b0;
      ref_pat = rs;
      key_d   = key_q;
      enter_d = 1'b0;
      start_d = 1'b0;
      aux_d   = 1'b0;
      ghost_d = sample && (rows_low(rs) > 3'd1) && (state_q != EMIT);
      case (state_q)
         SCAN: begin
            if (sample) begin
               if (rows_low(rs) == 3'd1) begin
                  row_d = row_sel;
                  load  = 1'b1;
                  if (DEBOUNCE_CNT == 1) state_d = EMIT;
                  else                   state_d = DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
         end
         DEBOUNCE: begin
            if (sample) begin
               if (!deb_match) begin
                  state_d = SCAN;
                  col_d   = col_q + 2'd1;
               end else if (reached) begin
                  state_d = EMIT;
               end
            end
         end
         EMIT: begin
            // Re-arm the counter to look for a run of all-ones samples (release).
            state_d = HELD;
            load    = 1'b1;
            ref_pat = 4'hF;
         end
         HELD: begin
            if (sample && reached) begin
               state_d = SCAN;
               col_d   = 2'd0;
            end
         end
         default: state_d = SCAN;
      endcase
      if (state_d == EMIT) begin
         key_d   = code;
         enter_d = (code <= 4'd9);
         start_d = (code == KEY_STAR);
         aux_d   = (code > 4'd9) && (code != KEY_STAR);
      end
      held_d = (state_d == HELD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SCAN;
         col_q   <= '0;
         div_q   <= '0;
         row_q   <= '0;
         key_q   <= '0;
         enter_q <= 1'b0;
         start_q <= 1'b0;
         aux_q   <= 1'b0;
         held_q  <= 1'b0;
         ghost_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         div_q   <= div_d;
         row_q   <= row_d;
         key_q   <= key_d;
         enter_q <= enter_d;
         start_q <= start_d;
         aux_q   <= aux_d;
         held_q  <= held_d;
         ghost_q <= ghost_d;
      end
   end

   assign col_drive  = ~(4'b0001 << col_q);
   assign keypad_in  = key_q;
   assign enter      = enter_q;
   assign start      = start_q;
   assign aux_strobe = aux_q;
   assign key_held   = held_q;
   assign ghost_err  = ghost_q;

endmodule
